// File: rtl/sensor_sched_pkg.sv
// Shared types, default timing constants and width helper for the sensor
// sample scheduler and its per-channel edge timeout monitors.
package sensor_sched_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_t;

   localparam int unsigned SAMPLE_DIV_44K1 = 2267;
   localparam int unsigned TIMEOUT_DEFAULT = 65535;

   function automatic int unsigned chan_bits(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/edge_timeout_monitor.sv
// One channel's oscillator-lost detector: saturating count of cycles since
// the last measured edge.
module edge_timeout_monitor
   import sensor_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic edge_flag,
   output logic lost
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   // an edge in the saturating cycle still clears the count
   always_comb begin
      cnt_d = cnt_q;
      if (edge_flag) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign lost = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sensor_sample_scheduler.sv
// Audio-rate snapshot and valid/ready streaming of frequency-meter durations.
// Optional SENSOR_SCHED_HOLD_LAST_EN: lost channels report their last good value.
//
// state | meaning
// IDLE  | waiting for the sample tick, no word offered
// SEND  | streaming shadow[idx] until the last channel is accepted
module sensor_sample_scheduler
   import sensor_sched_pkg::*;
#(
   parameter int unsigned CHANNELS       = 2,
   parameter int unsigned DATA_BITS      = 32,
   parameter int unsigned SAMPLE_DIV     = SAMPLE_DIV_44K1,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int unsigned OVERRUN_BITS   = 16
) (
   input  logic                            CLK,
   input  logic                            RESETN,
   input  logic [CHANNELS-1:0]             EDGE_FLAG,
   input  logic [CHANNELS*DATA_BITS-1:0]   DURATION,
   output logic                            SAMPLE_VALID,
   input  logic                            SAMPLE_READY,
   output logic [chan_bits(CHANNELS)-1:0]  SAMPLE_CHANNEL,
   output logic [DATA_BITS-1:0]            SAMPLE_DATA,
   output logic                            SAMPLE_LOST,
   output logic                            SAMPLE_LAST,
   output logic [OVERRUN_BITS-1:0]         OVERRUN_COUNT
);

   localparam int unsigned CW = chan_bits(CHANNELS);
   localparam int unsigned TW = (SAMPLE_DIV < 1) ? 1 : $clog2(SAMPLE_DIV + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(SAMPLE_DIV);
   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_SEND = SEND;

   logic [0:0]                      state_q, state_d;
   logic [CW-1:0]                   idx_q, idx_d;
   logic [TW-1:0]                   tick_cnt_q, tick_cnt_d;
   logic [CHANNELS*DATA_BITS-1:0]   shadow_data_q, shadow_data_d;
   logic [CHANNELS-1:0]             shadow_lost_q, shadow_lost_d;
   logic [OVERRUN_BITS-1:0]         overrun_q, overrun_d;
   logic [CHANNELS*DATA_BITS-1:0]   snap_data;
   logic [CHANNELS-1:0]             lost;
   logic                            tick;
   logic                            handshake;
   logic                            final_hs;
   logic                            capture;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_mon
      edge_timeout_monitor #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_mon (
         .clk_sys   (CLK),
         .rst_b     (RESETN),
         .edge_flag (EDGE_FLAG[g]),
         .lost      (lost[g])
      );
   end

   assign tick = (tick_cnt_q == TICK_MAX);

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

`ifdef SENSOR_SCHED_HOLD_LAST_EN
   logic [CHANNELS*DATA_BITS-1:0] last_good_q, last_good_d;

   always_comb begin
      snap_data   = DURATION;
      last_good_d = last_good_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (lost[i]) begin
            snap_data[i*DATA_BITS +: DATA_BITS] = last_good_q[i*DATA_BITS +: DATA_BITS];
         end else if (capture) begin
            last_good_d[i*DATA_BITS +: DATA_BITS] = DURATION[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         last_good_q <= '0;
      end else begin
         last_good_q <= last_good_d;
      end
   end
`else
   always_comb begin
      snap_data = DURATION;
   end
`endif

   assign handshake = (state_q == ST_SEND) && SAMPLE_READY;
   assign final_hs  = handshake && (idx_q == LAST_IDX);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      overrun_d = overrun_q;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               capture = 1'b1;
               state_d = ST_SEND;
               idx_d   = '0;
            end
         end
         ST_SEND: begin
            if (final_hs) begin
               idx_d = '0;
               // a tick on the closing handshake starts the next frame directly
               if (tick) begin
                  capture = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (handshake) begin
               idx_d = idx_q + CW'(1);
            end
            if (tick && !final_hs && (overrun_q != '1)) begin
               overrun_d = overrun_q + OVERRUN_BITS'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      shadow_data_d = capture ? snap_data : shadow_data_q;
      shadow_lost_d = capture ? lost      : shadow_lost_q;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         tick_cnt_q    <= '0;
         shadow_data_q <= '0;
         shadow_lost_q <= '0;
         overrun_q     <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         tick_cnt_q    <= tick_cnt_d;
         shadow_data_q <= shadow_data_d;
         shadow_lost_q <= shadow_lost_d;
         overrun_q     <= overrun_d;
      end
   end

   assign SAMPLE_VALID   = (state_q == ST_SEND);
   assign SAMPLE_CHANNEL = idx_q;
   assign SAMPLE_DATA    = SAMPLE_VALID ? shadow_data_q[int'(idx_q)*DATA_BITS +: DATA_BITS] : '0;
   assign SAMPLE_LOST    = SAMPLE_VALID && shadow_lost_q[idx_q];
   assign SAMPLE_LAST    = SAMPLE_VALID && (idx_q == LAST_IDX);
   assign OVERRUN_COUNT  = overrun_q;

endmodule

// File: tb/tb_sensor_sample_scheduler.sv
// Directed bench for sensor_sample_scheduler: per-cycle vector table plus
// hand-written stall, timeout, tick-on-last-handshake and reset sequences.
module tb_sensor_sample_scheduler;

   localparam int NV = 40;
   localparam logic [31:0] EXP_HOLD =
`ifdef SENSOR_SCHED_HOLD_LAST_EN
      32'h0000_2000;
`else
      32'h0000_FFFF;
`endif

   typedef struct {
      logic        ready;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        e_valid;
      logic        e_ch;
      logic [31:0] e_data;
      logic        e_lost;
      logic        e_last;
      logic [15:0] e_ovr;
   } vec_t;

   logic        clk = 1'b0;
   logic        RESETN = 1'b0;
   logic [1:0]  EDGE_FLAG;
   logic [63:0] DURATION;
   logic        SAMPLE_VALID;
   logic        SAMPLE_READY = 1'b1;
   logic [0:0]  SAMPLE_CHANNEL;
   logic [31:0] SAMPLE_DATA;
   logic        SAMPLE_LOST;
   logic        SAMPLE_LAST;
   logic [15:0] OVERRUN_COUNT;

   logic [31:0] dur0 = 32'h1000;
   logic [31:0] dur1 = 32'h2000;
   logic [1:0]  edge_en = 2'b11;
   logic [1:0]  edge_force = 2'b00;
   logic        pulse = 1'b0;
   int          pcnt = 0;

   int checks = 0;
   int failures = 0;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   assign DURATION  = {dur1, dur0};
   assign EDGE_FLAG = (pulse ? edge_en : 2'b00) | edge_force;

   sensor_sample_scheduler #(
      .CHANNELS       (2),
      .DATA_BITS      (32),
      .SAMPLE_DIV     (15),
      .TIMEOUT_CYCLES (100),
      .OVERRUN_BITS   (16)
   ) dut (
      .CLK            (clk),
      .RESETN         (RESETN),
      .EDGE_FLAG      (EDGE_FLAG),
      .DURATION       (DURATION),
      .SAMPLE_VALID   (SAMPLE_VALID),
      .SAMPLE_READY   (SAMPLE_READY),
      .SAMPLE_CHANNEL (SAMPLE_CHANNEL),
      .SAMPLE_DATA    (SAMPLE_DATA),
      .SAMPLE_LOST    (SAMPLE_LOST),
      .SAMPLE_LAST    (SAMPLE_LAST),
      .OVERRUN_COUNT  (OVERRUN_COUNT)
   );

   // edge pulses every 10 cycles on the enabled channels
   initial begin
      forever begin
         @(negedge clk);
         pcnt  = (pcnt == 9) ? 0 : pcnt + 1;
         pulse = (pcnt == 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string name);
      logic ok;
      ok = !SAMPLE_VALID;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = !SAMPLE_VALID;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_valid(input string name);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = SAMPLE_VALID;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic chk_word(input string name, input logic ch, input logic [31:0] data,
                           input logic lst, input logic last);
      chk({name, "_valid"}, 32'(SAMPLE_VALID), 32'd1);
      chk({name, "_ch"},    32'(SAMPLE_CHANNEL), 32'(ch));
      chk({name, "_data"},  SAMPLE_DATA, data);
      chk({name, "_lost"},  32'(SAMPLE_LOST), 32'(lst));
      chk({name, "_last"},  32'(SAMPLE_LAST), 32'(last));
   endtask

   initial begin
      logic quiet;

      for (int i = 0; i < NV; i++) begin
         vecs[i].ready   = 1'b1;
         vecs[i].d0      = (i < 20) ? 32'h1000 : 32'h1111;
         vecs[i].d1      = (i < 20) ? 32'h2000 : 32'h2222;
         vecs[i].e_valid = 1'b0;
         vecs[i].e_ch    = 1'b0;
         vecs[i].e_data  = 32'h0;
         vecs[i].e_lost  = 1'b0;
         vecs[i].e_last  = 1'b0;
         vecs[i].e_ovr   = 16'd0;
      end
      vecs[15].e_valid = 1'b1; vecs[15].e_ch = 1'b0; vecs[15].e_data = 32'h1000;
      vecs[16].e_valid = 1'b1; vecs[16].e_ch = 1'b1; vecs[16].e_data = 32'h2000; vecs[16].e_last = 1'b1;
      vecs[31].e_valid = 1'b1; vecs[31].e_ch = 1'b0; vecs[31].e_data = 32'h1111;
      vecs[32].ready   = 1'b0;
      vecs[32].e_valid = 1'b1; vecs[32].e_ch = 1'b0; vecs[32].e_data = 32'h1111;
      vecs[33].e_valid = 1'b1; vecs[33].e_ch = 1'b1; vecs[33].e_data = 32'h2222; vecs[33].e_last = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(SAMPLE_VALID), 32'd0);
      chk("rst_ch",    32'(SAMPLE_CHANNEL), 32'd0);
      chk("rst_data",  SAMPLE_DATA, 32'd0);
      chk("rst_lost",  32'(SAMPLE_LOST), 32'd0);
      chk("rst_last",  32'(SAMPLE_LAST), 32'd0);
      chk("rst_ovr",   32'(OVERRUN_COUNT), 32'd0);
      RESETN = 1'b1;

      // per-cycle table from release of reset
      for (int i = 0; i < NV; i++) begin
         SAMPLE_READY = vecs[i].ready;
         dur0         = vecs[i].d0;
         dur1         = vecs[i].d1;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 32'(SAMPLE_VALID), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_ovr", i), 32'(OVERRUN_COUNT), 32'(vecs[i].e_ovr));
         if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d_ch", i),   32'(SAMPLE_CHANNEL), 32'(vecs[i].e_ch));
            chk($sformatf("vec%0d_data", i), SAMPLE_DATA, vecs[i].e_data);
            chk($sformatf("vec%0d_lost", i), 32'(SAMPLE_LOST), 32'(vecs[i].e_lost));
            chk($sformatf("vec%0d_last", i), 32'(SAMPLE_LAST), 32'(vecs[i].e_last));
         end
      end

      // consumer stall across a tick: frame held, one overrun
      dur0 = 32'h1000;
      dur1 = 32'h2000;
      SAMPLE_READY = 1'b0;
      wait_idle("stall_idle");
      wait_valid("stall_first_valid");
      for (int j = 0; j < 20; j++) begin
         chk_word($sformatf("stall%0d", j), 1'b0, 32'h1000, 1'b0, 1'b0);
         dur0 = 32'h3000;
         @(negedge clk);
      end
      chk_word("stall_end", 1'b0, 32'h1000, 1'b0, 1'b0);
      chk("stall_ovr", 32'(OVERRUN_COUNT), 32'd1);
      SAMPLE_READY = 1'b1;
      @(negedge clk);
      chk_word("stall_ch1", 1'b1, 32'h2000, 1'b0, 1'b1);
      @(negedge clk);
      chk("stall_drop_valid", 32'(SAMPLE_VALID), 32'd0);

      // ch1 oscillator lost, then recovered by a single edge
      edge_en = 2'b01;
      repeat (120) @(negedge clk);
      wait_idle("lost_idle");
      dur1 = 32'hFFFF;
      wait_valid("lost_valid");
      chk_word("lost_ch0", 1'b0, 32'h3000, 1'b0, 1'b0);
      @(negedge clk);
      chk_word("lost_ch1", 1'b1, EXP_HOLD, 1'b1, 1'b1);
      @(negedge clk);
      chk("lost_drop_valid", 32'(SAMPLE_VALID), 32'd0);
      edge_force = 2'b10;
      @(negedge clk);
      edge_force = 2'b00;
      wait_valid("recover_valid");
      chk_word("recover_ch0", 1'b0, 32'h3000, 1'b0, 1'b0);
      @(negedge clk);
      chk_word("recover_ch1", 1'b1, 32'hFFFF, 1'b0, 1'b1);
      edge_en = 2'b11;

      // final handshake on the tick cycle
      wait_idle("coinc_idle");
      wait_valid("coinc_valid");
      SAMPLE_READY = 1'b0;
      repeat (14) @(negedge clk);
      chk_word("coinc_held", 1'b0, 32'h3000, 1'b0, 1'b0);
      SAMPLE_READY = 1'b1;
      @(negedge clk);
      chk_word("coinc_ch1", 1'b1, 32'hFFFF, 1'b0, 1'b1);
      @(negedge clk);
      chk_word("coinc_new_ch0", 1'b0, 32'h3000, 1'b0, 1'b0);
      chk("coinc_ovr", 32'(OVERRUN_COUNT), 32'd1);

      // asynchronous reset after ch0 accepted
      @(negedge clk);
      chk("mid_ch1", 32'(SAMPLE_CHANNEL), 32'd1);
      #2 RESETN = 1'b0;
      #1;
      chk("arst_valid", 32'(SAMPLE_VALID), 32'd0);
      chk("arst_ch",    32'(SAMPLE_CHANNEL), 32'd0);
      chk("arst_data",  SAMPLE_DATA, 32'd0);
      chk("arst_lost",  32'(SAMPLE_LOST), 32'd0);
      chk("arst_last",  32'(SAMPLE_LAST), 32'd0);
      chk("arst_ovr",   32'(OVERRUN_COUNT), 32'd0);
      @(negedge clk);
      RESETN = 1'b1;
      quiet = 1'b1;
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         if (SAMPLE_VALID) quiet = 1'b0;
      end
      chk("post_rst_quiet", 32'(quiet), 32'd1);
      @(negedge clk);
      chk_word("post_rst_first", 1'b0, 32'h3000, 1'b0, 1'b0);
      @(negedge clk);
      chk_word("post_rst_ch1", 1'b1, 32'hFFFF, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sensor_sample_scheduler.md
Name: sensor_sample_scheduler

Overview:
- Sequences readout of the per-channel frequency-meter results (pitch and volume oscillators) at a fixed audio-rate sample tick.
- Snapshots every channel's filtered DURATION on one cycle, then streams the channels one at a time over a valid/ready handshake to the CPU/AXI-side consumer.
- Also tracks per-channel edge timeouts ("oscillator lost") and counts frames dropped because the consumer was too slow.

Parameters:
- CHANNELS, 2, number of frequency-meter channels, 1..8
- DATA_BITS, 32, width of each channel DURATION
- SAMPLE_DIV, 2267, CLK cycles per sample tick minus 1; 100MHz/2268 ≈ 44.1kHz
- TIMEOUT_CYCLES, 65535, CLK cycles without EDGE_FLAG before a channel is flagged lost
- OVERRUN_BITS, 16, width of the saturating overrun counter

Ports:
- CLK  in  1  system clock, 100MHz
- RESETN  in  1  asynchronous reset, active low
- EDGE_FLAG  in  CHANNELS  per-channel one-cycle pulse from the frequency meter on each measured edge
- DURATION  in  CHANNELS*DATA_BITS  per-channel filtered period; channel i occupies bits [i*DATA_BITS +: DATA_BITS]
- SAMPLE_VALID  out  1  output word available
- SAMPLE_READY  in  1  consumer accepts the word when high together with SAMPLE_VALID
- SAMPLE_CHANNEL  out  max(1,$clog2(CHANNELS))  channel index of the current word
- SAMPLE_DATA  out  DATA_BITS  snapshotted duration
- SAMPLE_LOST  out  1  channel had timed out at snapshot time
- SAMPLE_LAST  out  1  current word is the last channel of its frame
- OVERRUN_COUNT  out  OVERRUN_BITS  dropped-frame count; saturates at all-ones

Behaviour:
- Reset (RESETN low, asynchronous): all outputs 0; FSM in IDLE; tick counter 0; timeout counters 0; lost flags 0.
- Tick counter:
  - Counts 0..SAMPLE_DIV, wraps to 0.
  - tick is asserted for one cycle when count == SAMPLE_DIV.
  - Tick period is SAMPLE_DIV+1 cycles.
- Timeout, per channel:
  - EDGE_FLAG[i] clears the counter to 0.
  - Otherwise the counter increments and saturates at TIMEOUT_CYCLES.
  - lost[i] = (counter == TIMEOUT_CYCLES).
  - If EDGE_FLAG arrives in the same cycle the counter would reach saturation, the clear wins.
- FSM states: IDLE, SEND.
  - IDLE + tick:
    - Capture all DURATION values and lost[] into shadow registers in that same cycle.
    - Go to SEND with idx=0.
    - SAMPLE_VALID rises the next cycle. Latency from tick to first VALID is 1 cycle.
  - SEND:
    - SAMPLE_VALID=1; SAMPLE_CHANNEL=idx; SAMPLE_DATA/SAMPLE_LOST come from shadow[idx]; SAMPLE_LAST=(idx==CHANNELS-1).
    - On VALID&&READY with idx<CHANNELS-1: idx+1, stay in SEND. Back-to-back transfers at one per cycle are allowed.
    - On VALID&&READY with idx==CHANNELS-1: go to IDLE and drop VALID the next cycle. If tick occurs in that same cycle, it is handled as an IDLE tick (new capture, stay in SEND, idx=0).
  - All SAMPLE_* outputs are held stable while VALID && !READY.
  - Shadow registers are never overwritten mid-frame.
- Overrun:
  - A tick arriving in SEND, other than on the final handshake cycle, drops the new frame.
  - OVERRUN_COUNT increments by 1, saturating.
  - The current frame continues draining unchanged.
- Reset asserted mid-frame aborts the frame immediately. No partial frame is resumed after reset.
- Outputs are registered; no combinational path from SAMPLE_READY to SAMPLE_VALID.

Optional Feature:
- Macro: SENSOR_SCHED_HOLD_LAST_EN.
- Defined:
  - Per channel, a last_good register captures DURATION at snapshot whenever lost[i]==0.
  - If lost[i]==1 at snapshot, the shadow takes last_good[i] instead of the live DURATION. SAMPLE_LOST is still 1.
  - last_good resets to 0.
- Undefined: the live DURATION is always captured. No last_good registers are instantiated.

Decomposition:
- Package sensor_sched_pkg holds:
  - sched_state_t enum {IDLE, SEND}
  - default constants SAMPLE_DIV_44K1=2267, TIMEOUT_DEFAULT=65535
  - function chan_bits(n) returning max(1,$clog2(n))
- Sub-module edge_timeout_monitor: one channel's saturating counter and lost output, parameterised by TIMEOUT_CYCLES; instantiated CHANNELS times via generate.

Test Plan:
- CHANNELS=2, SAMPLE_DIV=15, READY=1, DURATION0=0x1000, DURATION1=0x2000 -> every 16 cycles: ch0/0x1000/LAST=0, then ch1/0x2000/LAST=1 on consecutive cycles; VALID 1 cycle after tick; OVERRUN_COUNT=0.
- READY=0 for 20 cycles after first VALID, DURATION changed to 0x3000 meanwhile -> SAMPLE_DATA stays 0x1000; one tick dropped; OVERRUN_COUNT=1; frame resumes intact once READY=1.
- TIMEOUT_CYCLES=100, no EDGE_FLAG on ch1 for 120 cycles, pulses on ch0 every 10 -> next frame: ch0 LOST=0, ch1 LOST=1; a single ch1 EDGE_FLAG clears it for the following frame.
- Final handshake (ch1 accept) coincides with tick -> new frame starts next cycle with ch0; OVERRUN_COUNT unchanged.
- RESETN pulsed low mid-frame (after ch0 accepted) -> all outputs 0 asynchronously; after release, first VALID is 1 cycle after the first tick, starting at ch0.
- With SENSOR_SCHED_HOLD_LAST_EN: ch1 good at 0x2000, then times out with DURATION=0xFFFF -> SAMPLE_DATA=0x2000, LOST=1; without the macro -> 0xFFFF, LOST=1.
